// File: rtl/enable_table_loader.sv
// Enable table loader: skips earlier configurations in a byte stream, then writes one table's
// 2-bit entries (four per byte, MSB pair first). Optional checksum byte: ENABLE_TABLE_CHECKSUM_EN.
module enable_table_loader #(
    parameter int ADDR_BITS   = 9,
    parameter int CONFIG_BITS = 5
) (
    input  logic                   fpga_clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CONFIG_BITS-1:0] config_sel,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   byte_ready,
    output logic                   table_we,
    output logic [1:0]             table_val,
    output logic [ADDR_BITS-1:0]   table_write_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);
    localparam int BPT = (2 ** ADDR_BITS) / 4;
`ifdef ENABLE_TABLE_CHECKSUM_EN
    localparam int STRIDE = BPT + 1;
`else
    localparam int STRIDE = BPT;
`endif
    // one spare bit so the checksum stride can never overflow the skip counter
    localparam int SKIP_W = CONFIG_BITS + ADDR_BITS - 1;

    typedef enum logic [2:0] {IDLE, SKIP, LOAD, UNPACK, CHECK, DONE} state_t;

    state_t                 state, state_nxt;
    logic [SKIP_W-1:0]      skip_cnt;
    logic [SKIP_W-1:0]      skip_init;
    logic [7:0]             sreg;
    logic [1:0]             slot;
    logic [ADDR_BITS-1:0]   addr;
    logic                   wrote;
    logic                   accept;

    assign skip_init = SKIP_W'(config_sel) * SKIP_W'(STRIDE);
    assign accept    = byte_valid & byte_ready;

    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = (skip_init != '0) ? SKIP : LOAD;
            SKIP: begin
                byte_ready = 1'b1;
                if (byte_valid && skip_cnt == SKIP_W'(1)) state_nxt = LOAD;
            end
            LOAD: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = UNPACK;
            end
            UNPACK:  if (slot == 2'd3) state_nxt = (addr == '1) ? CHECK : LOAD;
            CHECK: begin
`ifdef ENABLE_TABLE_CHECKSUM_EN
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = DONE;
`else
                state_nxt = DONE;
`endif
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // addr/sreg always hold the entry currently (or last) written, so outputs are stable between writes
    always_ff @(posedge fpga_clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            skip_cnt <= '0;
            sreg     <= '0;
            slot     <= '0;
            addr     <= '0;
            wrote    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    skip_cnt <= skip_init;
                    wrote    <= 1'b0;
                end
                SKIP: if (accept) skip_cnt <= skip_cnt - SKIP_W'(1);
                LOAD: if (accept) begin
                    sreg  <= byte_data;
                    slot  <= 2'd0;
                    addr  <= wrote ? addr + ADDR_BITS'(1) : '0;
                    wrote <= 1'b1;
                end
                UNPACK: if (slot != 2'd3) begin
                    slot <= slot + 2'd1;
                    sreg <= {sreg[5:0], 2'b00};
                    addr <= addr + ADDR_BITS'(1);
                end
                default: ;
            endcase
        end
    end

    assign table_we         = (state == UNPACK);
    assign table_val        = sreg[7:6];
    assign table_write_addr = addr;
    assign busy             = (state != IDLE);
    assign done             = (state == DONE);

`ifdef ENABLE_TABLE_CHECKSUM_EN
    logic [7:0] csum;
    logic       err_q;

    always_ff @(posedge fpga_clk) begin
        if (!rst_n) begin
            csum  <= '0;
            err_q <= 1'b0;
        end else if (state == IDLE && start) begin
            csum  <= '0;
            err_q <= 1'b0;
        end else if (state == LOAD && accept) begin
            csum <= csum ^ byte_data;
        end else if (state == CHECK && accept && byte_data != csum) begin
            err_q <= 1'b1;
        end
    end

    assign error = err_q;
`else
    assign error = 1'b0;
`endif
endmodule
